// File: rtl/label_flattener.sv
// label_flattener: single ascending pass over the union-find equivalence table.
// Each entry is rewritten to its final root and the (label, root) pair is
// streamed downstream. Because parents never exceed their child index and
// lower entries are already flattened, root(i) = T[T[i]]: one extra read and
// no pointer chasing.
module label_flattener #(
    parameter int          WIDTH = 16,
    parameter int unsigned DEPTH = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] n_labels,
    output logic             busy,
    output logic             done,
    output logic             err_order,
    output logic [WIDTH-1:0] n_roots,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_label,
    output logic [WIDTH-1:0] out_root,
    output logic [WIDTH-1:0] ram_r_addr,
    input  logic [WIDTH-1:0] ram_data_out,
    output logic             ram_wen,
    output logic [WIDTH-1:0] ram_w_addr,
    output logic [WIDTH-1:0] ram_data_in
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_CHK, S_WR, S_EMIT, S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] i_q;
    logic [WIDTH-1:0] last_q;
    logic             busy_q, done_q, err_q, out_valid_q;
    logic [WIDTH-1:0] n_roots_q, out_label_q, out_root_q;

    assign busy      = busy_q;
    assign done      = done_q;
    assign err_order = err_q;
    assign n_roots   = n_roots_q;
    assign out_valid = out_valid_q;
    assign out_label = out_label_q;
    assign out_root  = out_root_q;

    // Control FSM with registered status/result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            last_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            n_roots_q   <= '0;
            out_valid_q <= 1'b0;
            out_label_q <= '0;
            out_root_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        // last_q wraps for n_labels==0, but that case skips straight to DONE
                        last_q    <= n_labels - WIDTH'(1);
                        i_q       <= WIDTH'(1);
                        n_roots_q <= '0;
                        err_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        if (n_labels <= WIDTH'(1)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RD;
                        end
                    end
                end
                S_RD: state_q <= S_CHK;
                S_CHK: begin
                    if (ram_data_out >= i_q) begin
                        // Out-of-order parent is flagged but the entry is treated as a root
                        if (ram_data_out > i_q) err_q <= 1'b1;
                        n_roots_q   <= n_roots_q + WIDTH'(1);
                        out_valid_q <= 1'b1;
                        out_label_q <= i_q;
                        out_root_q  <= i_q;
                        state_q     <= S_EMIT;
                    end else begin
                        state_q <= S_WR;
                    end
                end
                S_WR: begin
                    out_valid_q <= 1'b1;
                    out_label_q <= i_q;
                    out_root_q  <= ram_data_out;
                    state_q     <= S_EMIT;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_label_q <= '0;
                        out_root_q  <= '0;
                        if (i_q == last_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            i_q     <= i_q + WIDTH'(1);
                            state_q <= S_RD;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // RAM port drive. The CHK read address comes straight from read data so the
    // grandparent arrives in WR; the write is masked by reset so a pass cut
    // short never commits a half-finished entry.
    always_comb begin
        ram_r_addr  = '0;
        ram_wen     = 1'b0;
        ram_w_addr  = '0;
        ram_data_in = '0;
        case (state_q)
            S_RD:  ram_r_addr = i_q;
            S_CHK: if (ram_data_out < i_q) ram_r_addr = ram_data_out;
            S_WR: begin
                if (!reset) begin
                    ram_wen     = 1'b1;
                    ram_w_addr  = i_q;
                    ram_data_in = ram_data_out;
                end
            end
            default: ;
        endcase
    end

    // Table larger than the RAM would address past its end.
    a_depth: assert property (@(posedge clk) disable iff (reset)
        (start && state_q == S_IDLE) |-> (32'(n_labels) <= DEPTH));

endmodule
